// File: rtl/vec_stream_arb.sv
// vec_stream_arb: round-robin packet arbiter merging REQ_NO streams into one registered, ID-tagged output.
// Optional packet length check is compiled in with `define VEC_ARB_LEN_CHK_EN.
module vec_stream_arb #(
  parameter int BUS_WIDTH    = 128,
  parameter int REQ_NO       = 2,
  parameter int SUB_VEC_NO   = 8,
  parameter int REQ_ID_WIDTH = $clog2(REQ_NO)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_NO*BUS_WIDTH-1:0] up_Vector,
  input  logic [REQ_NO-1:0]           up_Valid,
  input  logic [REQ_NO-1:0]           up_Last,
  output logic [REQ_NO-1:0]           up_Ready,
  output logic [BUS_WIDTH-1:0]        dn_Vector,
  output logic [REQ_ID_WIDTH-1:0]     dn_ReqID,
  output logic                        dn_Valid,
  output logic                        dn_Last,
  input  logic                        dn_Ready
`ifdef VEC_ARB_LEN_CHK_EN
  ,
  output logic                        dn_LenErr
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_reg;
  logic [REQ_ID_WIDTH-1:0] r_Grant;
  logic [REQ_ID_WIDTH-1:0] r_Ptr;
  logic [REQ_ID_WIDTH-1:0] arb_idx;
  logic [REQ_ID_WIDTH-1:0] idx_hi;
  logic [REQ_ID_WIDTH-1:0] idx_any;
  logic [REQ_ID_WIDTH-1:0] grant_inc;
  logic                    found_hi;
  logic [BUS_WIDTH-1:0]    up_word [REQ_NO];
  logic                    can_take;
  logic                    accept;
  logic                    sel_last;
  logic                    pkt_end;

  generate
    if (REQ_NO < 2 || SUB_VEC_NO < 1) begin : g_bad_cfg
      $error("vec_stream_arb: needs REQ_NO >= 2 and SUB_VEC_NO >= 1");
    end
  endgenerate

  assign can_take = !dn_Valid || dn_Ready;

  generate
    for (genvar gi = 0; gi < REQ_NO; gi++) begin : g_req
      assign up_word[gi]  = up_Vector[gi*BUS_WIDTH +: BUS_WIDTH];
      assign up_Ready[gi] = (state_reg == LOCKED) && (r_Grant == REQ_ID_WIDTH'(gi)) && can_take;
    end
  endgenerate

  assign accept    = (state_reg == LOCKED) && can_take && up_Valid[r_Grant];
  assign sel_last  = up_Last[r_Grant];
  assign grant_inc = (r_Grant == REQ_ID_WIDTH'(REQ_NO - 1)) ? '0 : r_Grant + 1'b1;

  // Rotating priority: lowest valid index at or above r_Ptr wins, otherwise wrap to lowest valid index.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_any  = '0;
    for (int i = REQ_NO - 1; i >= 0; i--) begin
      if (up_Valid[i]) begin
        idx_any = REQ_ID_WIDTH'(i);
        if (i >= int'(r_Ptr)) begin
          found_hi = 1'b1;
          idx_hi   = REQ_ID_WIDTH'(i);
        end
      end
    end
    arb_idx = found_hi ? idx_hi : idx_any;
  end

`ifdef VEC_ARB_LEN_CHK_EN
  localparam int CNT_WIDTH = $clog2(SUB_VEC_NO + 1);

  logic [CNT_WIDTH-1:0] r_BeatCntr;
  logic [CNT_WIDTH-1:0] beat_no;
  logic                 len_full;
  logic                 len_err;

  // A packet reaching SUB_VEC_NO beats is cut there; the rest of the stream re-arbitrates.
  assign beat_no  = r_BeatCntr + 1'b1;
  assign len_full = (beat_no == CNT_WIDTH'(SUB_VEC_NO));
  assign pkt_end  = sel_last || len_full;
  assign len_err  = pkt_end && !(sel_last && len_full);
`else
  assign pkt_end  = sel_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      r_Grant    <= '0;
      r_Ptr      <= '0;
      dn_Vector  <= '0;
      dn_ReqID   <= '0;
      dn_Valid   <= 1'b0;
      dn_Last    <= 1'b0;
`ifdef VEC_ARB_LEN_CHK_EN
      r_BeatCntr <= '0;
      dn_LenErr  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (|up_Valid) begin
            r_Grant   <= arb_idx;
            state_reg <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && pkt_end) begin
            state_reg <= IDLE;
            r_Ptr     <= grant_inc;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (accept) begin
        dn_Vector <= up_word[r_Grant];
        dn_Last   <= pkt_end;
        dn_ReqID  <= r_Grant;
        dn_Valid  <= 1'b1;
`ifdef VEC_ARB_LEN_CHK_EN
        dn_LenErr  <= len_err;
        r_BeatCntr <= pkt_end ? '0 : beat_no;
`endif
      end else if (dn_Ready) begin
        dn_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_stream_arb.sv
`timescale 1ns/1ps
// Bench for vec_stream_arb: reset, a per-cycle vector table, a mid-packet reset sequence and
// queued packet streams scored against a packet-level round-robin model.
module tb_vec_stream_arb;
  localparam int BW  = 128;
  localparam int RN  = 2;
  localparam int SV  = 8;
  localparam int IDW = 1;
`ifdef VEC_ARB_LEN_CHK_EN
  localparam int MAXLEN = SV;
`else
  localparam int MAXLEN = 12;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [RN*BW-1:0] up_Vector;
  logic [RN-1:0]   up_Valid;
  logic [RN-1:0]   up_Last;
  logic [RN-1:0]   up_Ready;
  logic [BW-1:0]   dn_Vector;
  logic [IDW-1:0]  dn_ReqID;
  logic            dn_Valid;
  logic            dn_Last;
  logic            dn_Ready;
`ifdef VEC_ARB_LEN_CHK_EN
  logic            dn_LenErr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pkt_seq  = 0;
  int mdl_ptr  = 0;

  always #5 clk = ~clk;

  vec_stream_arb #(.BUS_WIDTH(BW), .REQ_NO(RN), .SUB_VEC_NO(SV)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_Vector (up_Vector),
    .up_Valid  (up_Valid),
    .up_Last   (up_Last),
    .up_Ready  (up_Ready),
    .dn_Vector (dn_Vector),
    .dn_ReqID  (dn_ReqID),
    .dn_Valid  (dn_Valid),
    .dn_Last   (dn_Last),
    .dn_Ready  (dn_Ready)
`ifdef VEC_ARB_LEN_CHK_EN
    ,
    .dn_LenErr (dn_LenErr)
`endif
  );

  typedef struct {
    logic [1:0] v;
    logic [1:0] l;
    logic       dr;
    logic [1:0] rdy;
    logic       dv;
    logic       dl;
    logic       id;
    int         acc;
  } row_t;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
    logic          first;
  } word_t;

  typedef struct {
    logic [BW-1:0]  data;
    logic           last;
    logic [IDW-1:0] id;
    logic           err;
  } exp_t;

  row_t  tbl [14];
  word_t drv_q [RN][$];
  exp_t  exp_q [$];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic row_t mkrow(input logic [1:0] v, input logic [1:0] l, input logic dr,
                                 input logic [1:0] rdy, input logic dv, input logic dl,
                                 input logic id, input int acc);
    row_t t;
    t.v = v; t.l = l; t.dr = dr; t.rdy = rdy; t.dv = dv; t.dl = dl; t.id = id; t.acc = acc;
    return t;
  endfunction

  function automatic logic [BW-1:0] tbl_word(input int k, input int r);
    return (BW'(k) << 8) | BW'(r + 1) | (BW'(r) << 127);
  endfunction

  function automatic logic [BW-1:0] mk(input int r, input int p, input int b);
    return (BW'(r + 1) << 96) | (BW'(p) << 48) | BW'(b);
  endfunction

  function automatic void drv_push(input int r, input logic [BW-1:0] d, input logic last, input logic first);
    word_t w;
    w.data = d; w.last = last; w.first = first;
    drv_q[r].push_back(w);
  endfunction

  function automatic void exp_push(input logic [BW-1:0] d, input logic last, input int r, input logic err);
    exp_t e;
    e.data = d; e.last = last; e.id = IDW'(r); e.err = err;
    exp_q.push_back(e);
  endfunction

  task automatic drive_row(input logic [1:0] v, input logic [1:0] l, input logic dr, input int k);
    up_Valid = v;
    up_Last  = l;
    dn_Ready = dr;
    for (int r = 0; r < RN; r++) up_Vector[r*BW +: BW] = tbl_word(k, r);
  endtask

  // Packets queued up front; the expected output order is derived at packet granularity:
  // each new packet comes from the first requester at or after the pointer that still has one.
  task automatic gen_stream(input int npk_lo, input int npk_hi, input int len_lo, input int len_hi,
                            output int total);
    int lens [RN][$];
    int seqs [RN][$];
    int r;
    int len;
    int s;
    total = 0;
    for (int q = 0; q < RN; q++) begin
      int npk;
      npk = $urandom_range(npk_hi, npk_lo);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(len_hi, len_lo);
        lens[q].push_back(len);
        seqs[q].push_back(pkt_seq);
        for (int b = 1; b <= len; b++) drv_push(q, mk(q, pkt_seq, b), b == len, b == 1);
        pkt_seq++;
      end
      total += npk;
    end
    for (int n = 0; n < total; n++) begin
      r = -1;
      for (int k = 0; k < RN; k++)
        if (r < 0 && lens[(mdl_ptr + k) % RN].size() > 0) r = (mdl_ptr + k) % RN;
      len = lens[r].pop_front();
      s   = seqs[r].pop_front();
      for (int b = 1; b <= len; b++) exp_push(mk(r, s, b), b == len, r, (b == len) && (len != SV));
      mdl_ptr = (r + 1) % RN;
    end
  endtask

  task automatic run_stream(input bit rnd, input int exp_bub, input int max_cycles, input string tag);
    int            bubbles;
    bit            started;
    int            cyc;
    logic [RN-1:0] acc;
    logic          xfer;
    logic [BW-1:0] g_data;
    logic          g_last;
    logic [IDW-1:0] g_id;
    logic          g_err;
    exp_t          e;
    bubbles = 0;
    started = 0;
    cyc     = 0;
    g_err   = 1'b0;
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      dn_Ready = rnd ? ($urandom_range(9, 0) < 6) : 1'b1;
      for (int r = 0; r < RN; r++) begin
        if (drv_q[r].size() > 0) begin
          up_Vector[r*BW +: BW] = drv_q[r][0].data;
          up_Last[r]  = drv_q[r][0].last;
          up_Valid[r] = drv_q[r][0].first || !rnd || ($urandom_range(9, 0) < 7);
        end else begin
          up_Valid[r] = 1'b0;
          up_Last[r]  = 1'b0;
        end
      end
      @(negedge clk);
      if (dn_Valid && !dn_Ready) chk({tag, "_stall_up_Ready"}, up_Ready, '0);
      chk({tag, "_up_Ready_onehot"}, ($countones(up_Ready) <= 1), 1'b1);
      if (started && !dn_Valid) bubbles++;
      acc    = up_Valid & up_Ready;
      xfer   = dn_Valid && dn_Ready;
      g_data = dn_Vector;
      g_last = dn_Last;
      g_id   = dn_ReqID;
`ifdef VEC_ARB_LEN_CHK_EN
      g_err  = dn_LenErr;
`endif
      @(posedge clk);
      #1;
      for (int r = 0; r < RN; r++) if (acc[r]) void'(drv_q[r].pop_front());
      if (xfer) begin
        started = 1;
        e = exp_q.pop_front();
        $display("txn %s id=%0d data=%0h last=%0b", tag, g_id, g_data, g_last);
        chk({tag, "_dn_Vector"}, g_data, e.data);
        chk({tag, "_dn_Last"}, g_last, e.last);
        chk({tag, "_dn_ReqID"}, g_id, e.id);
`ifdef VEC_ARB_LEN_CHK_EN
        chk({tag, "_dn_LenErr"}, g_err, e.err);
`endif
      end
      cyc++;
    end
    chk({tag, "_words_left"}, exp_q.size(), 0);
    if (exp_bub >= 0) chk({tag, "_bubbles"}, bubbles, exp_bub);
    exp_q.delete();
    for (int r = 0; r < RN; r++) drv_q[r].delete();
    up_Valid = '0;
  endtask

  initial begin
    int total;

    tbl[0]  = mkrow(2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    tbl[1]  = mkrow(2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1);
    tbl[2]  = mkrow(2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0,  2);
    tbl[3]  = mkrow(2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    tbl[4]  = mkrow(2'b11, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1,  4);
    tbl[5]  = mkrow(2'b01, 2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1,  4);
    tbl[6]  = mkrow(2'b01, 2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1,  4);
    tbl[7]  = mkrow(2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0,  7);
    tbl[8]  = mkrow(2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    tbl[9]  = mkrow(2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, -1);
    tbl[10] = mkrow(2'b10, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, -1);
    tbl[11] = mkrow(2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 11);
    tbl[12] = mkrow(2'b10, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    tbl[13] = mkrow(2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 13);

    // Reset held with every requester asking.
    rst       = 1'b1;
    up_Valid  = '1;
    up_Last   = '0;
    dn_Ready  = 1'b1;
    up_Vector = '0;
    for (int c = 0; c < 3; c++) begin
      for (int w = 0; w < RN*BW/32; w++) up_Vector[w*32 +: 32] = $urandom();
      @(posedge clk);
      #1;
      $display("reset cycle %0d", c);
      chk("rst_dn_Valid", dn_Valid, 1'b0);
      chk("rst_dn_Last", dn_Last, 1'b0);
      chk("rst_dn_ReqID", dn_ReqID, '0);
      chk("rst_dn_Vector", dn_Vector, '0);
      chk("rst_up_Ready", up_Ready, '0);
`ifdef VEC_ARB_LEN_CHK_EN
      chk("rst_dn_LenErr", dn_LenErr, 1'b0);
`endif
    end
    rst = 1'b0;

    for (int k = 0; k < 14; k++) begin
      drive_row(tbl[k].v, tbl[k].l, tbl[k].dr, k);
      @(negedge clk);
      chk($sformatf("tbl%0d_up_Ready", k), up_Ready, tbl[k].rdy);
      @(posedge clk);
      #1;
      $display("row %0d dn_Valid=%0b dn_Last=%0b dn_ReqID=%0d", k, dn_Valid, dn_Last, dn_ReqID);
      chk($sformatf("tbl%0d_dn_Valid", k), dn_Valid, tbl[k].dv);
      if (tbl[k].dv) begin
        chk($sformatf("tbl%0d_dn_Last", k), dn_Last, tbl[k].dl);
        chk($sformatf("tbl%0d_dn_ReqID", k), dn_ReqID, tbl[k].id);
        chk($sformatf("tbl%0d_dn_Vector", k), dn_Vector, tbl_word(tbl[k].acc, int'(tbl[k].id)));
      end
    end

    // Move the pointer to 1, start requester 1's packet, then reset after its third beat.
    drive_row(2'b01, 2'b01, 1'b1, 200);
    @(negedge clk); chk("mr_idle_up_Ready", up_Ready, 2'b00); @(posedge clk); #1;
    drive_row(2'b01, 2'b01, 1'b1, 201);
    @(negedge clk); chk("mr_single_up_Ready", up_Ready, 2'b01); @(posedge clk); #1;
    drive_row(2'b11, 2'b00, 1'b1, 202);
    @(negedge clk); chk("mr_arb_up_Ready", up_Ready, 2'b00); @(posedge clk); #1;
    for (int s = 3; s < 6; s++) begin
      drive_row(2'b11, 2'b00, 1'b1, 200 + s);
      @(negedge clk);
      chk("mr_grant1_up_Ready", up_Ready, 2'b10);
      @(posedge clk);
      #1;
      $display("midreset beat id=%0d data=%0h", dn_ReqID, dn_Vector);
      chk("mr_beat_dn_ReqID", dn_ReqID, 1'b1);
      chk("mr_beat_dn_Vector", dn_Vector, tbl_word(200 + s, 1));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_rst_dn_Valid", dn_Valid, 1'b0);
    chk("mr_rst_up_Ready", up_Ready, 2'b00);
    rst = 1'b0;

    // After reset requester 0 must win; requester 1's remaining beats form a fresh packet.
    drv_push(0, mk(0, 900, 1), 1'b0, 1'b1);
    drv_push(0, mk(0, 900, 2), 1'b1, 1'b0);
    for (int b = 4; b <= 8; b++) drv_push(1, mk(1, 901, b), b == 8, b == 4);
    exp_push(mk(0, 900, 1), 1'b0, 0, 1'b0);
    exp_push(mk(0, 900, 2), 1'b1, 0, 1'b1);
    for (int b = 4; b <= 8; b++) exp_push(mk(1, 901, b), b == 8, 1, b == 8);
    mdl_ptr = 0;
    run_stream(1'b0, 1, 400, "mr");
    mdl_ptr = 0;

    // Round robin with full-length packets and no backpressure.
    gen_stream(4, 4, SV, SV, total);
    run_stream(1'b0, total - 1, 1000, "rr");

    // Random lengths, mid-packet gaps and random backpressure.
    for (int it = 0; it < 3; it++) begin
      gen_stream(3, 6, 1, MAXLEN, total);
      run_stream(1'b1, -1, 4000, $sformatf("rnd%0d", it));
    end

`ifdef VEC_ARB_LEN_CHK_EN
    // Short packet flagged; overlong packet cut at SV beats and its tail re-arbitrated.
    for (int b = 1; b <= 5; b++) drv_push(0, mk(0, 950, b), b == 5, b == 1);
    for (int b = 1; b <= 10; b++) drv_push(0, mk(0, 951, b), b == 10, b == 1);
    for (int b = 1; b <= 5; b++) exp_push(mk(0, 950, b), b == 5, 0, b == 5);
    for (int b = 1; b <= 10; b++) exp_push(mk(0, 951, b), (b == SV) || (b == 10), 0, (b == SV) || (b == 10));
    run_stream(1'b0, 2, 400, "len");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
